// File: rtl/regblock_pkg.sv
// Shared types and constants for the operand-fetch register block.
// Optional build macro: REGBLOCK_BYPASS_EN (write-to-read forwarding).
package regblock_pkg;

    localparam int RWIDTH = 6;
    localparam int DWIDTH = 32;
    localparam int IMM_IN = 15;
    localparam int NREGS  = 1 << RWIDTH;

    typedef logic [RWIDTH-1:0] reg_addr_t;
    typedef logic [DWIDTH-1:0] word_t;
    typedef logic [IMM_IN-1:0] imm_t;

    function automatic word_t sext_imm(input imm_t imm);
        return {{(DWIDTH-IMM_IN){imm[IMM_IN-1]}}, imm};
    endfunction

endpackage

// File: rtl/reg_block_if.sv
// Decoder-to-operand-fetch bundle: addresses, write data, immediate, operands.
// Master is the decoder/controller side, slave is reg_block.
interface reg_block_if;
    import regblock_pkg::*;

    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;
    word_t     wd;
    logic      we;
    logic      mux_sel;
    imm_t      imm_in;
    word_t     opA;
    word_t     opB;
    word_t     opBwd;

    modport master (
        output rs, rt, rd, wd, we, mux_sel, imm_in,
        input  opA, opB, opBwd
    );

    modport slave (
        input  rs, rt, rd, wd, we, mux_sel, imm_in,
        output opA, opB, opBwd
    );

endinterface

// File: rtl/reg_file.sv
// 64x32 register array, two combinational reads, one clocked write.
// Forwarding of the in-flight write is enabled by REGBLOCK_BYPASS_EN.
module reg_file
    import regblock_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t ra_a,
    input  reg_addr_t ra_b,
    input  reg_addr_t wa,
    input  word_t     wd,
    input  logic      we,
    output word_t     rd_a,
    output word_t     rd_b
);

    word_t mem [NREGS];

    // Reset holds every entry at zero and blocks writes for its duration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

`ifdef REGBLOCK_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // A write blocked by reset must not leak through the forward path.
    assign fwd_a = we && !rst && (ra_a == wa);
    assign fwd_b = we && !rst && (ra_b == wa);

    assign rd_a = fwd_a ? wd : mem[ra_a];
    assign rd_b = fwd_b ? wd : mem[ra_b];
`else
    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];
`endif

endmodule

// File: rtl/reg_block.sv
// Operand fetch: register file reads plus immediate/register select for opB.
// REGBLOCK_BYPASS_EN enables same-cycle write forwarding in reg_file.
module reg_block
    import regblock_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    reg_block_if.slave  bus
);

    word_t rt_val;
    word_t rs_val;

    reg_file u_reg_file (
        .clk  (clk),
        .rst  (rst),
        .ra_a (bus.rs),
        .ra_b (bus.rt),
        .wa   (bus.rd),
        .wd   (bus.wd),
        .we   (bus.we),
        .rd_a (rs_val),
        .rd_b (rt_val)
    );

    assign bus.opA   = rs_val;
    assign bus.opBwd = rt_val;
    assign bus.opB   = bus.mux_sel ? sext_imm(bus.imm_in) : rt_val;

endmodule

// File: tb/tb_reg_block.sv
// Directed bench for reg_block with an array-based reference model.
// Honours REGBLOCK_BYPASS_EN when computing expected reads.
module tb_reg_block;
    import regblock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    reg_block_if bus ();

    reg_block dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: plain array of ints, cleared by reset.
    logic [31:0] model [64];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) model[i] = 32'd0;
        end else if (bus.we === 1'b1) begin
            model[bus.rd] = bus.wd;
        end
    end

    function automatic logic [31:0] exp_read(input int addr);
`ifdef REGBLOCK_BYPASS_EN
        if (!rst && bus.we && addr == int'(bus.rd)) return bus.wd;
`endif
        return model[addr];
    endfunction

    // Sign extension as signed arithmetic on the 15-bit field value.
    function automatic logic [31:0] exp_imm(input int v);
        int s;
        s = (v >= 16384) ? v - 32768 : v;
        return s;
    endfunction

    function automatic logic [31:0] exp_opb();
        if (bus.mux_sel) return exp_imm(int'(bus.imm_in));
        return exp_read(int'(bus.rt));
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_opA", bus.opA, exp_read(int'(bus.rs)));
            check("model_opBwd", bus.opBwd, exp_read(int'(bus.rt)));
            check("model_opB", bus.opB, exp_opb());
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [14:0] imm_vec [4];
    logic [31:0] imm_exp [4];

    initial begin
        bus.rs = '0;
        bus.rt = 6'd41;
        bus.rd = '0;
        bus.wd = '0;
        bus.we = 1'b0;
        bus.mux_sel = 1'b0;
        bus.imm_in = '0;
        #1 rst = 1'b1;
        step();
        chk_en = 1'b1;
        #1;
        check("rst_opA", bus.opA, 32'h0);
        check("rst_opB", bus.opB, 32'h0);
        check("rst_opBwd", bus.opBwd, 32'h0);

        bus.mux_sel = 1'b1;
        bus.imm_in = 15'h1FFF;
        #1;
        check("imm_pos_opB", bus.opB, 32'h00001FFF);
        check("imm_pos_opBwd", bus.opBwd, 32'h0);
        bus.imm_in = 15'h4000;
        #1;
        check("imm_neg_opB", bus.opB, 32'hFFFFC000);
        bus.mux_sel = 1'b0;
        #1;
        check("mux_reg_opB", bus.opB, 32'h0);

        imm_vec[0] = 15'h7FFF; imm_exp[0] = 32'hFFFFFFFF;
        imm_vec[1] = 15'h0000; imm_exp[1] = 32'h00000000;
        imm_vec[2] = 15'h3FFF; imm_exp[2] = 32'h00003FFF;
        imm_vec[3] = 15'h4001; imm_exp[3] = 32'hFFFFC001;
        bus.mux_sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.imm_in = imm_vec[i];
            #1;
            check("imm_vec", bus.opB, imm_exp[i]);
        end
        bus.mux_sel = 1'b0;

        step();
        rst = 1'b0;
        step();

        bus.we = 1'b1;
        bus.rd = 6'd63;
        bus.wd = 32'hFFAAFFAA;
        step();
        bus.we = 1'b0;
        bus.rt = 6'd63;
        #1;
        check("wr63_opB", bus.opB, 32'hFFAAFFAA);
        check("wr63_opBwd", bus.opBwd, 32'hFFAAFFAA);

        bus.we = 1'b1;
        bus.rd = 6'd12;
        bus.wd = 32'hAAAAAAAA;
        step();
        bus.we = 1'b0;
        bus.rs = 6'd12;
        bus.rt = 6'd63;
        #1;
        check("wr12_opA", bus.opA, 32'hAAAAAAAA);
        check("wr12_opBwd", bus.opBwd, 32'hFFAAFFAA);
        bus.wd = 32'h55555555;
        step();
        bus.wd = 32'h01234567;
        step();
        check("nowe_opA", bus.opA, 32'hAAAAAAAA);
        check("nowe_opBwd", bus.opBwd, 32'hFFAAFFAA);

        bus.rs = 6'd5;
        bus.rd = 6'd5;
        bus.wd = 32'h12345678;
        bus.we = 1'b1;
        #1;
`ifdef REGBLOCK_BYPASS_EN
        check("rw_same_pre", bus.opA, 32'h12345678);
`else
        check("rw_same_pre", bus.opA, 32'h0);
`endif
        step();
        bus.we = 1'b0;
        #1;
        check("rw_same_post", bus.opA, 32'h12345678);

        bus.we = 1'b1;
        bus.rd = 6'd0;
        bus.wd = 32'hDEADBEEF;
        step();
        bus.we = 1'b0;
        bus.rs = 6'd0;
        #1;
        check("r0_write", bus.opA, 32'hDEADBEEF);

        bus.rs = 6'd12;
        bus.rt = 6'd63;
        step();
        #1;
        rst = 1'b1;
        #1;
        check("async_opA", bus.opA, 32'h0);
        check("async_opBwd", bus.opBwd, 32'h0);
        bus.we = 1'b1;
        bus.rd = 6'd12;
        bus.wd = 32'h0BADF00D;
        step();
        step();
        bus.we = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_wr_drop", bus.opA, 32'h0);
        step();
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
